// File: rtl/fifo_sync_ext.sv
// rtl/fifo_sync_ext.sv - single-clock FIFO with arbitrary depth, level, programmable flags and flush
module fifo_sync_ext #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_THRESH  = DEPTH - 2,
  parameter int AE_THRESH  = 2,
  parameter int SHOW_AHEAD = 1,
  localparam int PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int LVL_W     = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  rd_valid,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic [LVL_W-1:0]      level,
  output logic                  overflow,
  output logic                  underflow
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  rd_acc;
  logic                  wr_acc;
  logic                  clear;

  assign clear        = !reset || flush;
  assign empty        = (level == '0);
  assign full         = (level == LVL_W'(DEPTH));
  assign almost_empty = (level <= LVL_W'(AE_THRESH));
  assign almost_full  = (level >= LVL_W'(AF_THRESH));

  // A full FIFO can still take a write when the same cycle frees a slot.
  assign rd_acc = rd_en && !empty;
  assign wr_acc = wr_en && (!full || rd_acc);

  always_ff @(posedge clk) begin
    if (!clear && wr_acc) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      // Depth need not be a power of two, so wrap on an explicit compare.
      if (wr_acc) begin
        wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (rd_acc) begin
        rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      end
      case ({wr_acc, rd_acc})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
      if (wr_en && !wr_acc) begin
        overflow <= 1'b1;
      end
      if (rd_en && empty) begin
        underflow <= 1'b1;
      end
    end
  end

  generate
    if (SHOW_AHEAD != 0) begin : g_show_ahead
      assign data_out = mem[rd_ptr];
      assign rd_valid = !empty;
    end else begin : g_registered
      logic [DATA_WIDTH-1:0] data_q;
      logic                  valid_q;

      always_ff @(posedge clk) begin
        if (clear) begin
          data_q  <= '0;
          valid_q <= 1'b0;
        end else begin
          valid_q <= rd_acc;
          if (rd_acc) begin
            data_q <= mem[rd_ptr];
          end
        end
      end

      assign data_out = data_q;
      assign rd_valid = valid_q;
    end
  endgenerate

endmodule

// File: doc/fifo_sync_ext.md
Name: fifo_sync_ext

Overview:
- Parametrised single-clock synchronous FIFO; next generation of the team's basic FIFO.
- Adds the following over the basic FIFO:
  - arbitrary (non-power-of-two) depth
  - fill-level output
  - programmable almost-full / almost-empty flags
  - selectable show-ahead or registered read mode
  - synchronous flush
  - sticky overflow/underflow error flags
- Buffers request/response streams between hash-table pipeline stages.

Parameters:
- DATA_WIDTH, 8: data word width in bits (>=1).
- DEPTH, 16: number of entries; any integer >=2, need not be a power of two.
- AF_THRESH, DEPTH-2: almost_full asserted when level >= AF_THRESH (1..DEPTH).
- AE_THRESH, 2: almost_empty asserted when level <= AE_THRESH (0..DEPTH-1).
- SHOW_AHEAD, 1: 1 = data_out combinationally shows head entry; 0 = data_out registered, valid one cycle after accepted read.
- Derived, not overridable: PTR_W = max(1, $clog2(DEPTH)); LVL_W = $clog2(DEPTH+1).

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- flush  in  1  synchronous clear of contents and error flags.
- wr_en  in  1  write request.
- data_in  in  DATA_WIDTH  write data.
- rd_en  in  1  read request.
- data_out  out  DATA_WIDTH  read data (timing per SHOW_AHEAD).
- rd_valid  out  1  SHOW_AHEAD=0: data_out holds a word popped last cycle; SHOW_AHEAD=1: equals !empty.
- empty  out  1  level == 0.
- full  out  1  level == DEPTH.
- almost_empty  out  1  level <= AE_THRESH.
- almost_full  out  1  level >= AF_THRESH.
- level  out  LVL_W  current number of stored words.
- overflow  out  1  sticky: write attempted while full and not accepted.
- underflow  out  1  sticky: read attempted while empty.

Behaviour:
- Reset (reset==0 at clk edge):
  - wr_ptr=0, rd_ptr=0, level=0, overflow=0, underflow=0, rd_valid=0; data_out register=0 (SHOW_AHEAD=0).
  - Memory contents are not cleared.
  - Reset overrides all other inputs, including mid-burst.
- Flush (reset==1, flush==1): same clearing as reset; wr_en/rd_en that cycle are ignored, with no flag update.
- Write accepted when wr_en && (!full || rd_accepted); stores data_in at wr_ptr.
- Read accepted when rd_en && !empty.
- Pointer wrap: a pointer at DEPTH-1 increments to 0. No power-of-two assumption; explicit compare required.
- Level update:
  - write only: +1
  - read only: -1
  - both: unchanged
- Full and wr_en&&rd_en: both accepted; level stays DEPTH; the word read is the old head.
- Full and wr_en only: write dropped, contents unchanged, overflow<=1.
- Empty and wr_en&&rd_en: write accepted, read rejected, level becomes 1, underflow<=1.
- Empty and rd_en only: no change except underflow<=1.
- Sticky flags stay set until reset or flush.
- Status flags (empty, full, almost_*, level) are pure functions of registered level; they update on the edge following the accepting cycle.
- SHOW_AHEAD=1:
  - data_out = mem[rd_ptr] combinationally.
  - A write into an empty FIFO is visible on data_out the cycle after the write edge.
  - data_out is undefined while empty; verification must not check it.
- SHOW_AHEAD=0:
  - On an accepted read, data_out <= mem[rd_ptr] and rd_valid<=1 at that edge.
  - Otherwise rd_valid<=0 and data_out holds its value.
  - Read latency is 1 cycle.
- No combinational path from data_in to data_out (no write-through bypass).

Test Plan:
- DEPTH=5, SHOW_AHEAD=1: write 0x11..0x15 -> full=1, level=5, almost_full=1 (AF=3). A 6th write (0x16) -> overflow=1, contents unchanged. Read 5 -> 0x11..0x15 in order, empty=1.
- DEPTH=5, wrap-around: stream 12 words with interleaved single reads/writes -> pointers wrap past 4 → 0; output order matches input; level never exceeds 5.
- Full FIFO, simultaneous wr_en/rd_en with data 0xAA -> read returns oldest word, level stays DEPTH. Drain -> 0xAA returned last.
- Empty FIFO, simultaneous wr_en/rd_en with 0x42 -> underflow=1, level=1. The next cycle shows 0x42 on data_out (SHOW_AHEAD=1).
- SHOW_AHEAD=0, DEPTH=16: write 0x01,0x02, then rd_en for two cycles -> rd_valid high on the two following cycles with 0x01 then 0x02; rd_valid=0 afterwards, data_out holds 0x02.
- Fill to level 3, pulse flush with wr_en=1 -> level=0, empty=1, flags cleared. Assert reset=0 mid-stream -> all outputs at reset values on the next edge.
